// File: rtl/box_mean_pkg.sv
// Shared types and constant helpers for the streaming box-mean filter.
package box_mean_pkg;

  localparam int unsigned POS_W = 16;

  typedef struct packed {
    logic [POS_W-1:0] col;
    logic [POS_W-1:0] row;
    logic             sof;
    logic             eol;
    logic             valid;
  } pos_t;

  function automatic int unsigned sum_w(input int unsigned k);
    return 8 + $clog2(k * k);
  endfunction

  // With recip = ceil(2^shift / k^2) the error term stays below k^2, and
  // the largest sum times that error is below 2^shift, so the floor is exact.
  function automatic int unsigned shift(input int unsigned k);
    return sum_w(k) + $clog2(k * k);
  endfunction

  function automatic int unsigned recip(input int unsigned k);
    longint unsigned p;
    longint unsigned d;
    p = 64'd1 << shift(k);
    d = 64'(k * k);
    return 32'((p + d - 64'd1) / d);
  endfunction

endpackage

// File: rtl/box_mean_linebuf.sv
// K-1 chained line RAMs, read-before-write at the current column.
module box_mean_linebuf #(
  parameter int unsigned LINES = 2,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 10
) (
  input  logic                clk,
  input  logic                en,
  input  logic [AW-1:0]       addr,
  input  logic [DW-1:0]       wdata,
  output logic [LINES*DW-1:0] rdata
);

  for (genvar j = 0; j < LINES; j++) begin : g_line
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] wr;

    // Line 0 takes the incoming pixel; deeper lines take the line above.
    if (j == 0) begin : g_head
      assign wr = wdata;
    end else begin : g_chain
      assign wr = rdata[(j-1)*DW +: DW];
    end

    assign rdata[j*DW +: DW] = mem[addr];

    always_ff @(posedge clk) begin
      if (en) mem[addr] <= wr;
    end
  end

endmodule

// File: rtl/box_mean_stream.sv
// Streaming KxK floor-mean filter: window/linebuffer, adder tree, reciprocal multiply.
module box_mean_stream
  import box_mean_pkg::*;
#(
  parameter int unsigned K         = 3,
  parameter int unsigned CH        = 1,
  parameter int unsigned MAX_WIDTH = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [$clog2(MAX_WIDTH+1)-1:0] cfg_width,
  input  logic [CH*8-1:0]                s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic                           s_sof,
  input  logic                           s_eol,
  output logic [CH*8-1:0]                m_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic                           m_sof,
  output logic                           m_eol,
  output logic                           err_line
);

  localparam int unsigned CW    = $clog2(MAX_WIDTH + 1);
  localparam int unsigned AW    = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int unsigned DW    = CH * 8;
  localparam int unsigned SW    = sum_w(K);
  localparam int unsigned RECIP = recip(K);
  localparam int unsigned SHIFT = shift(K);

  logic             adv, accept;
  logic [POS_W-1:0] col_q, row_q, cur_col, cur_row, col_n, row_n;
  logic [CW-1:0]    width_q, cur_width;
  logic             active_q, cur_active, last_col, mis;
  logic [(K-1)*DW-1:0] lb_rd;
  logic [DW-1:0]    newcol [K];
  logic [DW-1:0]    win [K][K];
  pos_t             p1, p1_n;
  logic             v2, sof2, eol2;
  logic [SW-1:0]    sum_c [CH];
  logic [SW-1:0]    sum_q [CH];
  logic [DW-1:0]    mean_c;

  assign adv     = m_ready || !m_valid;
  assign s_ready = !rst && adv;
  assign accept  = s_valid && s_ready;

  // Position of the pixel being offered; an sof pixel restarts the frame.
  always_comb begin
    cur_col    = s_sof ? '0 : col_q;
    cur_row    = s_sof ? '0 : row_q;
    cur_width  = s_sof ? cfg_width : width_q;
    cur_active = active_q || s_sof;
    last_col   = (cur_col == POS_W'(cur_width) - POS_W'(1));
    mis        = cur_active && (s_eol != last_col);
    col_n      = cur_col + POS_W'(1);
    row_n      = cur_row;
    if (s_eol || last_col) begin
      col_n = '0;
      row_n = (cur_row == {POS_W{1'b1}}) ? cur_row : cur_row + POS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q    <= '0;
      row_q    <= '0;
      width_q  <= '0;
      active_q <= 1'b0;
      err_line <= 1'b0;
    end else begin
      err_line <= accept && mis;
      if (accept && cur_active) begin
        col_q    <= col_n;
        row_q    <= row_n;
        width_q  <= cur_width;
        active_q <= 1'b1;
      end
    end
  end

  box_mean_linebuf #(
    .LINES(K - 1),
    .DEPTH(MAX_WIDTH),
    .DW   (DW),
    .AW   (AW)
  ) u_linebuf (
    .clk  (clk),
    .en   (accept),
    .addr (AW'(cur_col)),
    .wdata(s_data),
    .rdata(lb_rd)
  );

  // Window row 0 is the oldest line; row K-1 is the incoming pixel.
  always_comb begin
    for (int i = 0; i < int'(K) - 1; i++) begin
      newcol[i] = lb_rd[(int'(K) - 2 - i)*DW +: DW];
    end
    newcol[K-1] = s_data;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < int'(K); i++) begin
        for (int j = 0; j < int'(K) - 1; j++) begin
          win[i][j] <= win[i][j+1];
        end
        win[i][K-1] <= newcol[i];
      end
    end
  end

  always_comb begin
    p1_n.col   = cur_col;
    p1_n.row   = cur_row;
    p1_n.sof   = (cur_row == POS_W'(K - 1)) && (cur_col == POS_W'(K - 1));
    p1_n.eol   = last_col;
    p1_n.valid = accept && cur_active;
  end

  // Stage control: every stage advances together or holds together.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1       <= '0;
      v2       <= 1'b0;
      sof2     <= 1'b0;
      eol2     <= 1'b0;
      m_valid  <= 1'b0;
      m_sof    <= 1'b0;
      m_eol    <= 1'b0;
      m_data   <= '0;
    end else if (adv) begin
      p1      <= p1_n;
      v2      <= p1.valid && (p1.row >= POS_W'(K - 1)) && (p1.col >= POS_W'(K - 1));
      sof2    <= p1.sof;
      eol2    <= p1.eol;
      m_valid <= v2;
      m_sof   <= v2 && sof2;
      m_eol   <= v2 && eol2;
      m_data  <= mean_c;
    end
  end

  always_comb begin
    for (int c = 0; c < int'(CH); c++) begin
      sum_c[c] = '0;
      for (int i = 0; i < int'(K); i++) begin
        for (int j = 0; j < int'(K); j++) begin
          sum_c[c] = sum_c[c] + SW'(win[i][j][c*8 +: 8]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      for (int c = 0; c < int'(CH); c++) sum_q[c] <= sum_c[c];
    end
  end

  always_comb begin : mean_blk
    logic [63:0] prod;
    mean_c = '0;
    prod   = '0;
    for (int c = 0; c < int'(CH); c++) begin
      prod = 64'(sum_q[c]) * 64'(RECIP);
      mean_c[c*8 +: 8] = 8'(prod >> SHIFT);
    end
  end

endmodule
